// File: rtl/vx_mem_responder.sv
// vx_mem_responder
// Responder end of the core memory bus. Requests (valid/ready, rw, addr,
// byteen, data, tag) are served from an internal byte-enabled word array.
// Read responses come back in order after a fixed latency, through a
// first-word-fall-through response queue with backpressure. Credits cover
// the pipeline and the queue, so the queue can never overflow.
//
// Ports
//   clk, reset  clock; synchronous active-high reset
//   req_valid   request valid
//   req_rw      1 = write, 0 = read
//   req_addr    word address (upper bits above the array index are ignored)
//   req_byteen  write byte enables
//   req_data    write data
//   req_tag     request tag, returned on rsp_tag
//   req_ready   request accepted when req_valid && req_ready
//   rsp_valid   response valid
//   rsp_data    read data (holds last popped value while rsp_valid = 0)
//   rsp_tag     tag of the originating request
//   rsp_ready   response consumed when rsp_valid && rsp_ready
//   busy        responses in flight
//   pending     number of responses in flight (pipeline + queue)
module vx_mem_responder #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_SIZE       = 4,
    parameter int TAG_WIDTH       = 8,
    parameter int MEM_DEPTH       = 1024,
    parameter int LATENCY         = 4,
    parameter int RSP_QUEUE_DEPTH = 8,
    parameter int WRITE_ACK       = 0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   req_valid,
    input  logic                                   req_rw,
    input  logic [ADDR_WIDTH-1:0]                  req_addr,
    input  logic [DATA_SIZE-1:0]                   req_byteen,
    input  logic [DATA_SIZE*8-1:0]                 req_data,
    input  logic [TAG_WIDTH-1:0]                   req_tag,
    output logic                                   req_ready,
    output logic                                   rsp_valid,
    output logic [DATA_SIZE*8-1:0]                 rsp_data,
    output logic [TAG_WIDTH-1:0]                   rsp_tag,
    input  logic                                   rsp_ready,
    output logic                                   busy,
    output logic [$clog2(RSP_QUEUE_DEPTH+1)-1:0]   pending
);

    localparam int DATA_WIDTH = DATA_SIZE * 8;
    localparam int IDX_WIDTH  = $clog2(MEM_DEPTH);
    localparam int PEND_WIDTH = $clog2(RSP_QUEUE_DEPTH + 1);
    localparam int PTR_WIDTH  = $clog2(RSP_QUEUE_DEPTH);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = PEND_WIDTH'(RSP_QUEUE_DEPTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [IDX_WIDTH-1:0]  idx;

    logic                  req_fire;
    logic                  rsp_fire;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  push_valid;
    logic [DATA_WIDTH-1:0] push_data;
    logic [TAG_WIDTH-1:0]  push_tag;

    logic [DATA_WIDTH-1:0] q_data [RSP_QUEUE_DEPTH];
    logic [TAG_WIDTH-1:0]  q_tag  [RSP_QUEUE_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PEND_WIDTH-1:0] q_count;
    logic [DATA_WIDTH-1:0] last_data;
    logic [TAG_WIDTH-1:0]  last_tag;

    // Upper address bits alias onto the array.
    assign idx = req_addr[IDX_WIDTH-1:0];

    if (ADDR_WIDTH > IDX_WIDTH) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^req_addr[ADDR_WIDTH-1:IDX_WIDTH];
    end

    // Credits count everything in flight, so accepting only below the queue
    // depth is enough to guarantee a free queue slot for every response.
    assign req_ready = !reset && (pending < PEND_MAX);
    assign req_fire  = req_valid && req_ready;
    assign in_valid  = req_fire && (!req_rw || (WRITE_ACK != 0));
    assign in_data   = req_rw ? '0 : mem[idx];
    assign in_tag    = req_tag;

    always_ff @(posedge clk) begin
        if (req_fire && req_rw) begin
            for (int b = 0; b < DATA_SIZE; b++) begin
                if (req_byteen[b]) begin
                    mem[idx][b*8 +: 8] <= req_data[b*8 +: 8];
                end
            end
        end
    end

    // The queue write itself provides the final cycle of latency, so the
    // shift pipeline holds LATENCY-1 stages and vanishes for LATENCY = 1.
    if (LATENCY == 1) begin : g_no_pipe
        assign push_valid = in_valid;
        assign push_data  = in_data;
        assign push_tag   = in_tag;
    end else begin : g_pipe
        localparam int STAGES = LATENCY - 1;
        logic [STAGES-1:0]     stg_valid;
        logic [DATA_WIDTH-1:0] stg_data [STAGES];
        logic [TAG_WIDTH-1:0]  stg_tag  [STAGES];

        always_ff @(posedge clk) begin
            if (reset) begin
                stg_valid <= '0;
            end else begin
                stg_valid[0] <= in_valid;
                for (int i = 1; i < STAGES; i++) begin
                    stg_valid[i] <= stg_valid[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            stg_data[0] <= in_data;
            stg_tag[0]  <= in_tag;
            for (int i = 1; i < STAGES; i++) begin
                stg_data[i] <= stg_data[i-1];
                stg_tag[i]  <= stg_tag[i-1];
            end
        end

        assign push_valid = stg_valid[STAGES-1];
        assign push_data  = stg_data[STAGES-1];
        assign push_tag   = stg_tag[STAGES-1];
    end

    // Outside a valid response the outputs show the last popped entry.
    assign rsp_valid = (q_count != '0);
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign rsp_data  = rsp_valid ? q_data[rd_ptr] : last_data;
    assign rsp_tag   = rsp_valid ? q_tag[rd_ptr]  : last_tag;

    always_ff @(posedge clk) begin
        if (push_valid) begin
            q_data[wr_ptr] <= push_data;
            q_tag[wr_ptr]  <= push_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            q_count   <= '0;
            last_data <= '0;
            last_tag  <= '0;
        end else begin
            if (push_valid) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (rsp_fire) begin
                rd_ptr    <= rd_ptr + PTR_WIDTH'(1);
                last_data <= q_data[rd_ptr];
                last_tag  <= q_tag[rd_ptr];
            end
            case ({push_valid, rsp_fire})
                2'b10:   q_count <= q_count + PEND_WIDTH'(1);
                2'b01:   q_count <= q_count - PEND_WIDTH'(1);
                default: q_count <= q_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            case ({in_valid, rsp_fire})
                2'b10:   pending <= pending + PEND_WIDTH'(1);
                2'b01:   pending <= pending - PEND_WIDTH'(1);
                default: pending <= pending;
            endcase
        end
    end

    assign busy = (pending != '0);

    queue_no_overflow: assert property (
        @(posedge clk) disable iff (reset) !(push_valid && (q_count == PEND_MAX))
    );

endmodule

// File: tb/tb_vx_mem_responder.sv
// tb_vx_mem_responder
// Self-checking bench for vx_mem_responder with default parameters.
// A behavioural model (word array plus a queue of expected responses with
// due cycles) predicts every output each cycle; directed table vectors and
// hand-written sequences add constant expectations for the corner cases.
module tb_vx_mem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_rw;
    logic [31:0] req_addr;
    logic [3:0]  req_byteen;
    logic [31:0] req_data;
    logic [7:0]  req_tag;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [7:0]  rsp_tag;
    logic        rsp_ready;
    logic        busy;
    logic [3:0]  pending;

    vx_mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_rw     (req_rw),
        .req_addr   (req_addr),
        .req_byteen (req_byteen),
        .req_data   (req_data),
        .req_tag    (req_tag),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_ready  (rsp_ready),
        .busy       (busy),
        .pending    (pending)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  tag;
        int          due;
    } rsp_t;

    typedef struct {
        logic        v;
        logic        rw;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [7:0]  tag;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [7:0]  exp_tag;
        logic [3:0]  exp_pend;
    } vec_t;

    rsp_t        exp_q[$];
    logic [31:0] model_mem [1024];
    logic [31:0] last_data;
    logic [7:0]  last_tag;
    int          cycle;
    int          tests_run;
    int          tests_failed;
    vec_t        tbl [20];

    // One comparison: counts it, and reports a FAIL line on mismatch.
    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Compares every output against the model for the current cycle, then
    // advances the model by what the coming clock edge will do.
    task automatic checkOutput();
        int          exp_pend;
        logic        exp_ready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [7:0]  exp_tag;
        exp_pend  = exp_q.size();
        exp_ready = !reset && (exp_pend < 8);
        exp_valid = 1'b0;
        exp_data  = last_data;
        exp_tag   = last_tag;
        if (exp_pend > 0 && exp_q[0].due <= cycle) begin
            exp_valid = 1'b1;
            exp_data  = exp_q[0].data;
            exp_tag   = exp_q[0].tag;
        end
        checkVal("req_ready", req_ready, exp_ready);
        if (!reset) begin
            checkVal("rsp_valid", rsp_valid, exp_valid);
            checkVal("rsp_data", rsp_data, exp_data);
            checkVal("rsp_tag", rsp_tag, exp_tag);
            checkVal("pending", pending, exp_pend);
            checkVal("busy", busy, exp_pend != 0);
        end
        if (reset) begin
            exp_q.delete();
            last_data = '0;
            last_tag  = '0;
        end else begin
            if (exp_valid && rsp_ready) begin
                last_data = exp_q[0].data;
                last_tag  = exp_q[0].tag;
                void'(exp_q.pop_front());
            end
            if (req_valid && exp_ready) begin
                if (req_rw) begin
                    for (int b = 0; b < 4; b++) begin
                        if (req_byteen[b]) model_mem[req_addr[9:0]][b*8 +: 8] = req_data[b*8 +: 8];
                    end
                end else begin
                    exp_q.push_back('{model_mem[req_addr[9:0]], req_tag, cycle + 4});
                end
            end
        end
    endtask

    // Drives one cycle of inputs and runs the model check once they settle.
    task automatic applyStimulus(input logic rst, input logic v, input logic rw,
                                 input logic [31:0] a, input logic [3:0] be,
                                 input logic [31:0] d, input logic [7:0] t, input logic rr);
        reset      = rst;
        req_valid  = v;
        req_rw     = rw;
        req_addr   = a;
        req_byteen = be;
        req_data   = d;
        req_tag    = t;
        rsp_ready  = rr;
        #2;
        checkOutput();
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic idle(input logic rr);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 8'h0, rr);
    endtask

    task automatic readReq(input logic [31:0] a, input logic [7:0] t, input logic rr);
        applyStimulus(1'b0, 1'b1, 1'b0, a, 4'h0, 32'h0, t, rr);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cycle        = 0;
        last_data    = '0;
        last_tag     = '0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_rw       = 1'b0;
        req_addr     = '0;
        req_byteen   = '0;
        req_data     = '0;
        req_tag      = '0;
        rsp_ready    = 1'b0;

        // Directed vectors, rsp_ready held high; expectations derived by hand.
        tbl[0]  = '{1'b1, 1'b1, 32'h10,  4'hF, 32'hDEADBEEF, 8'h00, 1'b0, 32'h0,        8'h00, 4'd0};
        tbl[1]  = '{1'b1, 1'b1, 32'h20,  4'hF, 32'h11223344, 8'h00, 1'b0, 32'h0,        8'h00, 4'd0};
        tbl[2]  = '{1'b1, 1'b1, 32'h20,  4'h2, 32'h0000AA00, 8'h00, 1'b0, 32'h0,        8'h00, 4'd0};
        tbl[3]  = '{1'b1, 1'b0, 32'h10,  4'h0, 32'h0,        8'h05, 1'b0, 32'h0,        8'h00, 4'd0};
        tbl[4]  = '{1'b1, 1'b0, 32'h20,  4'h0, 32'h0,        8'h06, 1'b0, 32'h0,        8'h00, 4'd1};
        tbl[5]  = '{1'b1, 1'b1, 32'h3,   4'hF, 32'hCAFEF00D, 8'h00, 1'b0, 32'h0,        8'h00, 4'd2};
        tbl[6]  = '{1'b1, 1'b0, 32'h3,   4'h0, 32'h0,        8'h07, 1'b0, 32'h0,        8'h00, 4'd2};
        tbl[7]  = '{1'b1, 1'b0, 32'h403, 4'h0, 32'h0,        8'h08, 1'b1, 32'hDEADBEEF, 8'h05, 4'd3};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        8'h00, 1'b1, 32'h1122AA44, 8'h06, 4'd3};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        8'h00, 1'b0, 32'h1122AA44, 8'h06, 4'd2};
        tbl[10] = '{1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        8'h00, 1'b1, 32'hCAFEF00D, 8'h07, 4'd2};
        tbl[11] = '{1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        8'h00, 1'b1, 32'hCAFEF00D, 8'h08, 4'd1};
        tbl[12] = '{1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        8'h00, 1'b0, 32'hCAFEF00D, 8'h08, 4'd0};
        tbl[13] = '{1'b1, 1'b1, 32'h10,  4'h0, 32'h0,        8'h00, 1'b0, 32'hCAFEF00D, 8'h08, 4'd0};
        tbl[14] = '{1'b1, 1'b0, 32'h10,  4'h0, 32'h0,        8'h09, 1'b0, 32'hCAFEF00D, 8'h08, 4'd0};
        tbl[15] = '{1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        8'h00, 1'b0, 32'hCAFEF00D, 8'h08, 4'd1};
        tbl[16] = '{1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        8'h00, 1'b0, 32'hCAFEF00D, 8'h08, 4'd1};
        tbl[17] = '{1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        8'h00, 1'b0, 32'hCAFEF00D, 8'h08, 4'd1};
        tbl[18] = '{1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        8'h00, 1'b1, 32'hDEADBEEF, 8'h09, 4'd1};
        tbl[19] = '{1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        8'h00, 1'b0, 32'hDEADBEEF, 8'h09, 4'd0};

        @(posedge clk);
        #1;

        // Reset for two cycles, then check the cleared state.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 8'h0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 8'h0, 1'b0);
        nextCycle();
        idle(1'b1);
        checkVal("init_rsp_valid", rsp_valid, 32'd0);
        checkVal("init_rsp_data", rsp_data, 32'd0);
        checkVal("init_pending", pending, 32'd0);
        checkVal("init_req_ready", req_ready, 32'd1);
        nextCycle();

        // Table-driven directed vectors: latency, byte enables, aliasing.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, tbl[i].v, tbl[i].rw, tbl[i].addr, tbl[i].be,
                          tbl[i].data, tbl[i].tag, 1'b1);
            checkVal($sformatf("tbl%0d_rsp_valid", i), rsp_valid, tbl[i].exp_valid);
            checkVal($sformatf("tbl%0d_rsp_data", i), rsp_data, tbl[i].exp_data);
            checkVal($sformatf("tbl%0d_rsp_tag", i), rsp_tag, tbl[i].exp_tag);
            checkVal($sformatf("tbl%0d_pending", i), pending, tbl[i].exp_pend);
            nextCycle();
        end

        // Backpressure: nine back-to-back reads with rsp_ready low.
        for (int i = 0; i < 9; i++) begin
            readReq(32'h10, 8'h20 + 8'(i), 1'b0);
            nextCycle();
        end
        idle(1'b0);
        checkVal("full_pending", pending, 32'd8);
        checkVal("full_req_ready", req_ready, 32'd0);
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            nextCycle();
        end
        readReq(32'h10, 8'h30, 1'b1);
        checkVal("full_pop_req_ready", req_ready, 32'd0);
        checkVal("full_pop_rsp_valid", rsp_valid, 32'd1);
        checkVal("full_pop_rsp_tag", rsp_tag, 32'h20);
        nextCycle();
        readReq(32'h10, 8'h30, 1'b1);
        checkVal("popread_pending", pending, 32'd7);
        checkVal("popread_req_ready", req_ready, 32'd1);
        nextCycle();
        idle(1'b0);
        checkVal("popread_pending_after", pending, 32'd7);
        nextCycle();
        for (int i = 0; i < 16; i++) begin
            idle(1'b1);
            nextCycle();
        end

        // Reset with five responses in flight.
        for (int i = 0; i < 5; i++) begin
            readReq(32'h20, 8'h40 + 8'(i), 1'b0);
            nextCycle();
        end
        idle(1'b0);
        checkVal("prerst_pending", pending, 32'd5);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 8'h0, 1'b0);
        nextCycle();
        idle(1'b1);
        checkVal("rst_rsp_valid", rsp_valid, 32'd0);
        checkVal("rst_pending", pending, 32'd0);
        checkVal("rst_busy", busy, 32'd0);
        checkVal("rst_rsp_data", rsp_data, 32'd0);
        nextCycle();
        readReq(32'h10, 8'h44, 1'b1);
        nextCycle();
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            nextCycle();
        end
        idle(1'b1);
        checkVal("postrst_rsp_valid", rsp_valid, 32'd1);
        checkVal("postrst_rsp_data", rsp_data, 32'hDEADBEEF);
        checkVal("postrst_rsp_tag", rsp_tag, 32'h44);
        nextCycle();

        // Random traffic over sixteen indices with random upper address bits.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 32'(i), 4'hF, $urandom(), 8'h0, 1'b1);
            nextCycle();
        end
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            a      = $urandom();
            a[9:4] = '0;
            applyStimulus(1'b0, $urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0, a,
                          4'($urandom()), $urandom(), 8'($urandom()), $urandom_range(0, 9) < 7);
            nextCycle();
        end
        for (int i = 0; i < 20; i++) begin
            idle(1'b1);
            nextCycle();
        end
        idle(1'b1);
        checkVal("drain_pending", pending, 32'd0);
        checkVal("drain_busy", busy, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
